instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 79 +++++++
 tb/tb_instruction_fetch_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : PC register and IF/ID pipeline register with redirect/stall
//               control. Optional performance counters are enabled by
//               defining FETCH_PERF_COUNTERS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] Inst_Address,
    input  logic [31:0] Instruction,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_target,
    output logic        id_valid,
    output logic [63:0] id_pc,
    output logic [31:0] id_instruction,
    output logic [63:0] id_pc_plus4,
`ifdef FETCH_PERF_COUNTERS_EN
    output logic [63:0] fetch_count,
    output logic [63:0] bubble_count,
`endif
    output logic        misaligned_redirect
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [63:0] pc;
    logic [63:0] pc_next_seq;

    // Memory address depends only on the PC register, never on Instruction.
    assign Inst_Address = pc;
    assign pc_next_seq  = pc + 64'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc                  <= RESET_PC;
            id_valid            <= 1'b0;
            id_pc               <= 64'h0;
            id_pc_plus4         <= 64'h0;
            id_instruction      <= NOP_INSTR;
            misaligned_redirect <= 1'b0;
        end else if (redirect) begin
            // Redirect wins over stall; the decode slot becomes a NOP bubble.
            pc                  <= {redirect_target[63:2], 2'b00};
            id_valid            <= 1'b0;
            id_instruction      <= NOP_INSTR;
            misaligned_redirect <= |redirect_target[1:0];
        end else if (stall) begin
            misaligned_redirect <= 1'b0;
        end else begin
            pc                  <= pc_next_seq;
            id_valid            <= 1'b1;
            id_pc               <= pc;
            id_instruction      <= Instruction;
            id_pc_plus4         <= pc_next_seq;
            misaligned_redirect <= 1'b0;
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count  <= 64'h0;
            bubble_count <= 64'h0;
        end else if (redirect || stall) begin
            bubble_count <= bubble_count + 64'd1;
        end else begin
            fetch_count  <= fetch_count + 64'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_target = 64'h0;

    logic [63:0] addr, addr_r;
    logic [31:0] instr, instr_r;
    logic        id_valid, id_valid_r;
    logic [63:0] id_pc, id_pc_r, id_pc4, id_pc4_r;
    logic [31:0] id_instr, id_instr_r;
    logic        mis, mis_r;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [63:0] fcnt, bcnt, fcnt_r, bcnt_r;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [63:0] m_pc, m_id_pc, m_pc4;
    logic        m_valid, m_mis;
    logic [31:0] m_instr;
    logic [63:0] m_fc, m_bc;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0) return 32'h1000_0513;
        if (a == 64'h4) return 32'h0050_0293;
        return a[31:0] ^ a[63:32] ^ 32'hA5C3_0F00;
    endfunction

    always_comb instr   = mem_word(addr);
    always_comb instr_r = mem_word(addr_r);

    instruction_fetch_unit dut (
        .clk(clk), .reset(reset), .Inst_Address(addr), .Instruction(instr),
        .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
        .id_valid(id_valid), .id_pc(id_pc), .id_instruction(id_instr),
        .id_pc_plus4(id_pc4),
`ifdef FETCH_PERF_COUNTERS_EN
        .fetch_count(fcnt), .bubble_count(bcnt),
`endif
        .misaligned_redirect(mis)
    );

    instruction_fetch_unit #(.RESET_PC(64'h100)) dut_r (
        .clk(clk), .reset(reset), .Inst_Address(addr_r), .Instruction(instr_r),
        .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
        .id_valid(id_valid_r), .id_pc(id_pc_r), .id_instruction(id_instr_r),
        .id_pc_plus4(id_pc4_r),
`ifdef FETCH_PERF_COUNTERS_EN
        .fetch_count(fcnt_r), .bubble_count(bcnt_r),
`endif
        .misaligned_redirect(mis_r)
    );

    // Drive one cycle of inputs at negedge, advance the model, sample #1 after posedge.
    task automatic step(input logic rst, input logic st, input logic rd, input logic [63:0] tgt);
        @(negedge clk);
        reset = rst; stall = st; redirect = rd; redirect_target = tgt;
        if (rst) begin
            m_pc = 64'h0; m_valid = 0; m_id_pc = 0; m_pc4 = 0; m_instr = NOP;
            m_mis = 0; m_fc = 0; m_bc = 0;
        end else if (rd) begin
            m_pc = tgt & ~64'd3; m_valid = 0; m_instr = NOP;
            m_mis = (tgt % 4) != 0; m_bc = m_bc + 1;
        end else if (st) begin
            m_mis = 0; m_bc = m_bc + 1;
        end else begin
            m_valid = 1; m_id_pc = m_pc; m_instr = mem_word(m_pc);
            m_pc = m_pc + 4; m_pc4 = m_pc; m_mis = 0; m_fc = m_fc + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 1, 1, 64'h40);
        checks++; if (addr !== 64'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", addr, 64'h0); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        checks++; if (id_pc !== 64'h0 || id_pc4 !== 64'h0) begin failures++; $display("FAIL reset_id_pc got=%h/%h exp=0/0", id_pc, id_pc4); end
        checks++; if (id_instr !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", id_instr, NOP); end
        checks++; if (mis !== 1'b0) begin failures++; $display("FAIL reset_mis got=%b exp=0", mis); end
        checks++; if (addr_r !== 64'h100) begin failures++; $display("FAIL reset_pc_param got=%h exp=100", addr_r); end
    endtask

    task automatic test_free_run();
        step(0, 0, 0, 0);
        checks++; if (id_valid !== 1'b1 || id_pc !== 64'h0 || id_instr !== 32'h1000_0513)
            begin failures++; $display("FAIL first_fetch got v=%b pc=%h i=%h exp v=1 pc=0 i=10000513", id_valid, id_pc, id_instr); end
        step(0, 0, 0, 0);
        checks++; if (id_pc !== 64'h4 || id_instr !== 32'h0050_0293 || id_pc4 !== 64'h8)
            begin failures++; $display("FAIL second_fetch got pc=%h i=%h p4=%h exp 4/00500293/8", id_pc, id_instr, id_pc4); end
        checks++; if (addr !== 64'h8) begin failures++; $display("FAIL free_run_addr got=%h exp=8", addr); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            checks++; if (addr !== 64'h8 || id_valid !== 1'b1 || id_pc !== 64'h4 ||
                          id_instr !== 32'h0050_0293 || id_pc4 !== 64'h8)
                begin failures++; $display("FAIL stall_hold[%0d] got a=%h v=%b pc=%h i=%h p4=%h", i, addr, id_valid, id_pc, id_instr, id_pc4); end
        end
        step(0, 0, 0, 0);
        checks++; if (id_pc !== 64'h8 || addr !== 64'hC) begin failures++; $display("FAIL stall_resume got pc=%h a=%h exp 8/c", id_pc, addr); end
    endtask

    task automatic test_redirect_stall();
        step(0, 1, 1, 64'h18);
        checks++; if (addr !== 64'h18 || id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 64'h8 || id_pc4 !== 64'hC)
            begin failures++; $display("FAIL redirect_bubble got a=%h v=%b i=%h pc=%h p4=%h", addr, id_valid, id_instr, id_pc, id_pc4); end
        checks++; if (mis !== 1'b0) begin failures++; $display("FAIL redirect_aligned_mis got=%b exp=0", mis); end
        step(0, 0, 0, 0);
        checks++; if (id_pc !== 64'h18 || id_valid !== 1'b1) begin failures++; $display("FAIL redirect_follow got pc=%h v=%b exp 18/1", id_pc, id_valid); end
    endtask

    task automatic test_misaligned();
        step(0, 0, 1, 64'h1A);
        checks++; if (addr !== 64'h18 || mis !== 1'b1) begin failures++; $display("FAIL misaligned got a=%h m=%b exp 18/1", addr, mis); end
        step(0, 0, 0, 0);
        checks++; if (mis !== 1'b0) begin failures++; $display("FAIL misaligned_pulse got=%b exp=0", mis); end
    endtask

    task automatic test_wrap();
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 0, 0, 0);
        checks++; if (id_pc !== 64'hFFFF_FFFF_FFFF_FFFC || addr !== 64'h0 || id_pc4 !== 64'h0)
            begin failures++; $display("FAIL wrap got pc=%h a=%h p4=%h", id_pc, addr, id_pc4); end
    endtask

    task automatic test_random();
        int bad = 0;
        // Resynchronise the model with a reset before the random run.
        step(1, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            logic st, rd;
            logic [63:0] tgt;
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 5) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7))
                                               : {$urandom, $urandom};
            step(0, st, rd, tgt);
            checks++;
            if (addr !== m_pc || id_valid !== m_valid || id_pc !== m_id_pc || id_instr !== m_instr ||
                id_pc4 !== m_pc4 || mis !== m_mis) begin
                failures++;
                if (bad++ < 5)
                    $display("FAIL random[%0d] got a=%h v=%b pc=%h i=%h p4=%h m=%b exp a=%h v=%b pc=%h i=%h p4=%h m=%b",
                             i, addr, id_valid, id_pc, id_instr, id_pc4, mis,
                             m_pc, m_valid, m_id_pc, m_instr, m_pc4, m_mis);
            end
`ifdef FETCH_PERF_COUNTERS_EN
            checks++;
            if (fcnt !== m_fc || bcnt !== m_bc) begin
                failures++;
                if (bad++ < 5) $display("FAIL random_cnt[%0d] got f=%0d b=%0d exp f=%0d b=%0d", i, fcnt, bcnt, m_fc, m_bc);
            end
`endif
        end
    endtask

    task automatic test_mid_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 1, 1, 64'h44);
        checks++; if (id_valid !== 1'b0 || addr !== 64'h0 || id_instr !== NOP)
            begin failures++; $display("FAIL mid_reset got v=%b a=%h i=%h", id_valid, addr, id_instr); end
        checks++; if (id_valid_r !== 1'b0 || addr_r !== 64'h100 || mis_r !== 1'b0)
            begin failures++; $display("FAIL mid_reset_param got v=%b a=%h m=%b exp 0/100/0", id_valid_r, addr_r, mis_r); end
`ifdef FETCH_PERF_COUNTERS_EN
        checks++; if (fcnt_r !== 64'h0 || bcnt_r !== 64'h0)
            begin failures++; $display("FAIL mid_reset_cnt got f=%0d b=%0d exp 0/0", fcnt_r, bcnt_r); end
`endif
        step(0, 0, 0, 0);
        checks++; if (id_valid_r !== 1'b1 || id_pc_r !== 64'h100 || addr_r !== 64'h104)
            begin failures++; $display("FAIL post_reset_param got v=%b pc=%h a=%h exp 1/100/104", id_valid_r, id_pc_r, addr_r); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_stall();
        test_misaligned();
        test_wrap();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
